// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between requesters A/B, the arbiter and the FIFO write port.
// Latency: none, wiring only.
// Backpressure: carries a_ready/b_ready back to requesters and wfull into the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DSIZE = 8
);
    logic             a_valid;
    logic [DSIZE-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [DSIZE-1:0] b_data;
    logic             b_ready;
    logic             wfull;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic [1:0]       grant;
    logic [7:0]       beat_cnt;

    // Requester/FIFO side: drives requests and the full flag.
    modport master (
        output a_valid, a_data, b_valid, b_data, wfull,
        input  a_ready, b_ready, winc, wdata, grant, beat_cnt
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, wfull,
        output a_ready, b_ready, winc, wdata, grant, beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between requesters A and B.
// Latency: one cycle from valid to grant when idle; write path is same-cycle combinational.
// Backpressure: wfull gates ready/winc in the same cycle; a stall holds grant and beat count indefinitely.
module fifo_wr_arbiter #(
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input logic            clk,
    input logic            rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GNT_A  = 2'b01;
    localparam logic [1:0] ST_GNT_B  = 2'b10;
    localparam logic       LAST_A    = 1'b0;
    localparam logic       LAST_B    = 1'b1;
    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    logic [1:0] r_grant;
    logic [7:0] r_beat_cnt;
    logic       r_last;

    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_xfer;
    logic       w_own_vld;
    logic       w_oth_vld;
    logic       w_me;
    logic [1:0] w_other;
    logic [1:0] w_nxt_grant;
    logic [7:0] w_nxt_cnt;
    logic       w_nxt_last;

    // Both valid: the one not served last wins; otherwise the valid one; none -> idle.
    function automatic logic [1:0] f_pick(input logic av, input logic bv, input logic last);
        logic [1:0] g;
        g = ST_IDLE;
        if (av && bv)  g = (last == LAST_B) ? ST_GNT_A : ST_GNT_B;
        else if (av)   g = ST_GNT_A;
        else if (bv)   g = ST_GNT_B;
        return g;
    endfunction

    assign w_gnt_a = (r_grant == ST_GNT_A);
    assign w_gnt_b = (r_grant == ST_GNT_B);
    assign w_xfer  = ((w_gnt_a & bus.a_valid) | (w_gnt_b & bus.b_valid)) & ~bus.wfull;

    assign bus.a_ready  = w_gnt_a & ~bus.wfull;
    assign bus.b_ready  = w_gnt_b & ~bus.wfull;
    assign bus.winc     = w_xfer;
    assign bus.wdata    = w_gnt_a ? bus.a_data : (w_gnt_b ? bus.b_data : '0);
    assign bus.grant    = r_grant;
    assign bus.beat_cnt = r_beat_cnt;

    // Next-state: arbitrate from idle, count beats, hand over at burst end or on release.
    always_comb begin
        w_nxt_grant = r_grant;
        w_nxt_cnt   = r_beat_cnt;
        w_nxt_last  = r_last;
        w_own_vld   = w_gnt_a ? bus.a_valid : bus.b_valid;
        w_oth_vld   = w_gnt_a ? bus.b_valid : bus.a_valid;
        w_me        = w_gnt_a ? LAST_A : LAST_B;
        w_other     = w_gnt_a ? ST_GNT_B : ST_GNT_A;
        if (!(w_gnt_a || w_gnt_b)) begin
            w_nxt_grant = f_pick(bus.a_valid, bus.b_valid, r_last);
        end else if (!w_own_vld) begin
            // Release (also covers a valid drop during a stall).
            w_nxt_last  = w_me;
            w_nxt_cnt   = 8'd0;
            w_nxt_grant = f_pick(bus.a_valid, bus.b_valid, w_me);
        end else if (w_xfer) begin
            if (r_beat_cnt == LAST_BEAT) begin
                w_nxt_last  = w_me;
                w_nxt_cnt   = 8'd0;
                w_nxt_grant = w_oth_vld ? w_other : r_grant;
            end else begin
                w_nxt_cnt = r_beat_cnt + 8'd1;
            end
        end
        // Otherwise a stall: everything holds.
    end

    // State registers with synchronous reset; B counts as last served so A goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= ST_IDLE;
            r_beat_cnt <= 8'd0;
            r_last     <= LAST_B;
        end else begin
            r_grant    <= w_nxt_grant;
            r_beat_cnt <= w_nxt_cnt;
            r_last     <= w_nxt_last;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Two-requester, round-robin burst arbiter that shares the async FIFO's single write port (`winc`/`wdata`, gated by `wfull`) between requesters A and B. It sits in front of the FIFO's write side and runs in the write-clock domain; its `clk` is the clock that clocks the FIFO write pointer. Grants are held for up to `BURST` beats, then re-arbitrated. The requester with the older grant always wins contention.

## Interface
- `DSIZE`, default 8: data width; must match the FIFO `DSIZE`.
- `BURST`, default 4: maximum beats per grant, range 1..255.
- `clk` input 1: write-side clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_valid` input 1: requester A has a beat to write.
- `a_data` input DSIZE: requester A beat.
- `a_ready` output 1: A's beat is accepted this cycle.
- `b_valid` input 1: requester B has a beat to write.
- `b_data` input DSIZE: requester B beat.
- `b_ready` output 1: B's beat is accepted this cycle.
- `wfull` input 1: FIFO full flag, already in the write domain.
- `winc` output 1: FIFO write enable.
- `wdata` output DSIZE: FIFO write data.
- `grant` output 2: registered grant; 00 = idle, 01 = A, 10 = B; 11 is never driven.
- `beat_cnt` output 8: registered count of beats accepted in the current grant.

## Operation
State is held in three registers:
- `grant`, which encodes the FSM states IDLE, GNT_A and GNT_B.
- `beat_cnt`.
- `last`, the requester served most recently. It resets to B, so A has first priority.

Combinational outputs:
- `a_ready` = GNT_A & ~wfull.
- `b_ready` = GNT_B & ~wfull.
- `xfer` = (GNT_A & a_valid | GNT_B & b_valid) & ~wfull.
- `winc` = `xfer`.
- `wdata` = `a_data` in GNT_A, `b_data` in GNT_B, and 0 in IDLE.

Pick function (used by IDLE and by release):
- If both requesters are valid, grant the one that is not `last`.
- Otherwise grant the valid one.
- If neither is valid, go to IDLE.

IDLE:
- Apply the pick function; the chosen grant is registered for the next cycle.

GNT_X, evaluated each cycle:
- **Transfer, beat_cnt < BURST-1:** increment `beat_cnt`; grant holds.
- **Transfer, beat_cnt == BURST-1 (burst end):** set `last` = X and `beat_cnt` = 0.
  - If the other requester is valid, grant the other.
  - Else, if X is still valid, re-grant X.
  - Else, go to IDLE.
- **X_valid == 0 (release):** set `last` = X and `beat_cnt` = 0, then apply the pick function.
- **Stall (X_valid & wfull):** no transfer; `beat_cnt` and `grant` hold, with no timeout.

`beat_cnt` never exceeds BURST-1. Each 8-bit counter width holds any legal `BURST`.

## Timing
- **Reset:** `rst` sampled high sets, on the next edge, `grant` = 00, `beat_cnt` = 0 and `last` = B. While in that state, `winc`, `a_ready`, `b_ready` = 0 and `wdata` = 0. Reset overrides every transition, including mid-burst and during a stall.
- **Arbitration latency:** one cycle from IDLE. A valid sampled in cycle N gives `grant` and `ready` in cycle N+1.
- **No bubbles within a grant:** back-to-back beats are accepted every cycle while valid & ~wfull.
- **Zero-bubble handoff:**
  - Burst end in cycle N with the other requester valid puts the other's `ready` in cycle N+1.
  - A release in cycle N with the other requester valid also hands over in N+1.
- **Write path is combinational and same-cycle:** `wfull` to `ready`/`winc`, and valid/data to `winc`/`wdata`. No write is ever issued while `wfull` = 1.
- **Valid drop during a stall:** treated as a release on that cycle.
- **Data handshake:** requesters must hold data stable while valid & ~ready.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles with `a_valid` = `b_valid` = 1 -> `grant` = 00, `winc` = 0 throughout. After `rst` falls, `grant` = 01 one cycle later.
- **A alone:** A streams 10 beats (0x00..0x09) with BURST = 4 and `wfull` = 0 -> 10 consecutive `winc` cycles with `wdata` 0x00..0x09. `grant` stays 01 (re-granted at each burst end), and `beat_cnt` runs 0,1,2,3,0,...
- **Contention:** A and B both continuously valid -> `winc` high every cycle. Grants alternate A×4, B×4, A×4 with no idle cycle between them.
- **Full stall:** `wfull` = 1 for 3 cycles after A's 2nd beat -> `a_ready` = `winc` = 0 and `beat_cnt` = 2 held, `grant` stays 01. Beats 3–4 then complete and B is granted the next cycle.
- **Early release:** A drops `a_valid` after 1 beat while B is valid -> `grant` = 10 the next cycle, and A wins the next contention.
- **Reset mid-burst:** `rst` is pulsed in GNT_B at `beat_cnt` = 2 -> the next cycle shows `grant` = 00 and `beat_cnt` = 0. With both valid after release, A is granted first.
